// File: rtl/warblade_pkg.sv
// Shared definitions for the vblank scheduler: FSM encoding, default sizing
// and the grant timer width helper.
package warblade_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      NEXT  = 2'd2
   } sched_state_e;

   localparam int DEF_N_CLIENTS   = 4;
   localparam int DEF_TIMEOUT_CYC = 1024;

   function automatic int timerWidth(input int cyc);
      return (cyc > 1) ? $clog2(cyc) : 1;
   endfunction

   localparam int DEF_TIMER_W = timerWidth(DEF_TIMEOUT_CYC);

endpackage

// File: rtl/vblank_scheduler_if.sv
// Client handshake bundle: per-client enable and done strobes in, one-hot grant out.
interface vblank_scheduler_if import warblade_pkg::*; #(
   parameter int N_CLIENTS = DEF_N_CLIENTS
);

   logic [N_CLIENTS-1:0] en_mask_in;
   logic [N_CLIENTS-1:0] done_in;
   logic [N_CLIENTS-1:0] req_out;

   modport master (
      input  en_mask_in,
      input  done_in,
      output req_out
   );

   modport slave (
      output en_mask_in,
      output done_in,
      input  req_out
   );

endinterface

// File: rtl/sched_grant_timer.sv
// Counts pclk cycles while a grant is held; expire_o flags the final allowed cycle.
module sched_grant_timer import warblade_pkg::*; #(
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int TW          = timerWidth(TIMEOUT_CYC)
) (
   input  logic pclk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic run_i,
   output logic expire_o
);

   localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] cnt_q;

   assign expire_o = run_i && (cnt_q == LAST);

   // Holds at LAST so a stalled FSM cannot wrap the count back to zero.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (run_i && !expire_o) begin
         cnt_q <= cnt_q + TW'(1);
      end
   end

endmodule

// File: rtl/vblank_scheduler.sv
// Sequences enabled game-logic clients one at a time during each vertical
// blank, with per-grant timeout and vblank-overrun detection.
module vblank_scheduler import warblade_pkg::*; #(
   parameter int N_CLIENTS   = DEF_N_CLIENTS,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                 pclk,
   input  logic                 rst_n,
   input  logic                 vblnk_in,
   input  logic                 clr_err_in,
   vblank_scheduler_if.master   cl,
   output logic                 busy_out,
   output logic                 frame_start_out,
   output logic [15:0]          frame_cnt_out,
   output logic [N_CLIENTS-1:0] timeout_err_out,
   output logic                 overrun_out
);

   localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
   localparam int TW = timerWidth(TIMEOUT_CYC);

   sched_state_e         state_q;
   logic [IW-1:0]        idx_q;
   logic [N_CLIENTS-1:0] mask_q;
   logic [N_CLIENTS-1:0] req_q;
   logic                 busy_q;
   logic                 fstart_q;
   logic [15:0]          fcnt_q;
   logic [N_CLIENTS-1:0] terr_q;
   logic                 ovr_q;
   logic                 vblnk_q;

   logic                 frameStart;
   logic                 doneHit;
   logic                 expire;
   logic                 firstHit;
   logic [IW-1:0]        firstIdx;
   logic                 nextHit;
   logic [IW-1:0]        nextIdx;

   assign frameStart = vblnk_in && !vblnk_q;
   assign doneHit    = cl.done_in[idx_q];

   // Lowest enabled client for a new frame, and lowest enabled client above
   // the current one for the NEXT step.
   always_comb begin
      firstHit = 1'b0;
      firstIdx = '0;
      nextHit  = 1'b0;
      nextIdx  = '0;
      for (int i = N_CLIENTS - 1; i >= 0; i--) begin
         if (cl.en_mask_in[i]) begin
            firstHit = 1'b1;
            firstIdx = IW'(i);
         end
         if (mask_q[i] && (i > int'(idx_q))) begin
            nextHit = 1'b1;
            nextIdx = IW'(i);
         end
      end
   end

   sched_grant_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TW          (TW)
   ) u_timer (
      .pclk     (pclk),
      .rst_n    (rst_n),
      .clear_i  (state_q != GRANT),
      .run_i    (state_q == GRANT),
      .expire_o (expire)
   );

   // Error clears are written first so that a same-cycle set overrides them.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         mask_q   <= '0;
         req_q    <= '0;
         busy_q   <= 1'b0;
         fstart_q <= 1'b0;
         fcnt_q   <= '0;
         terr_q   <= '0;
         ovr_q    <= 1'b0;
         vblnk_q  <= 1'b0;
      end else begin
         vblnk_q  <= vblnk_in;
         fstart_q <= 1'b0;
         if (clr_err_in) begin
            terr_q <= '0;
            ovr_q  <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (frameStart) begin
                  fstart_q <= 1'b1;
                  fcnt_q   <= fcnt_q + 16'd1;
                  mask_q   <= cl.en_mask_in;
                  if (firstHit) begin
                     state_q <= GRANT;
                     idx_q   <= firstIdx;
                     req_q   <= N_CLIENTS'(1) << firstIdx;
                     busy_q  <= 1'b1;
                  end
               end
            end
            GRANT: begin
               if (!vblnk_in) begin
                  ovr_q   <= 1'b1;
                  req_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (doneHit) begin
                  req_q   <= '0;
                  state_q <= NEXT;
               end else if (expire) begin
                  terr_q[idx_q] <= 1'b1;
                  req_q         <= '0;
                  state_q       <= NEXT;
               end
            end
            NEXT: begin
               if (!vblnk_in) begin
                  ovr_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (nextHit) begin
                  state_q <= GRANT;
                  idx_q   <= nextIdx;
                  req_q   <= N_CLIENTS'(1) << nextIdx;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               req_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cl.req_out      = req_q;
   assign busy_out        = busy_q;
   assign frame_start_out = fstart_q;
   assign frame_cnt_out   = fcnt_q;
   assign timeout_err_out = terr_q;
   assign overrun_out     = ovr_q;

endmodule

// File: tb/tb_vblank_scheduler.sv
// Directed bench for vblank_scheduler: clients answer after a programmable
// number of grant cycles (0 = never), outputs compared against hand-made tables.
module tb_vblank_scheduler;

   localparam int NC = 4;
   localparam int TO = 16;

   logic          pclk = 1'b0;
   logic          rst_n;
   logic          vblnk_in;
   logic          clr_err_in;
   logic          busy_out;
   logic          frame_start_out;
   logic [15:0]   frame_cnt_out;
   logic [NC-1:0] timeout_err_out;
   logic          overrun_out;

   vblank_scheduler_if #(.N_CLIENTS(NC)) cl();

   vblank_scheduler #(
      .N_CLIENTS   (NC),
      .TIMEOUT_CYC (TO)
   ) dut (
      .pclk            (pclk),
      .rst_n           (rst_n),
      .vblnk_in        (vblnk_in),
      .clr_err_in      (clr_err_in),
      .cl              (cl),
      .busy_out        (busy_out),
      .frame_start_out (frame_start_out),
      .frame_cnt_out   (frame_cnt_out),
      .timeout_err_out (timeout_err_out),
      .overrun_out     (overrun_out)
   );

   always #5 pclk = ~pclk;

   int            errCount   = 0;
   int            checkCount = 0;
   int            lat [NC];
   int            age [NC];
   int            expFrames  = 0;
   int            pulses;
   int            hold;
   logic [NC-1:0] reqOr;
   logic          busySeen;
   logic [3:0]    exp35 [0:12] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2,
                                   4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0};

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [NC-1:0] m, input logic c);
      vblnk_in      = v;
      cl.en_mask_in = m;
      clr_err_in    = c;
   endtask

   task automatic setLat(input int a0, input int a1, input int a2, input int a3);
      lat[0] = a0;
      lat[1] = a1;
      lat[2] = a2;
      lat[3] = a3;
   endtask

   // One clock, then the client model raises done after lat[i] granted cycles.
   task automatic tick();
      logic [NC-1:0] d;
      @(posedge pclk);
      #2;
      d = '0;
      for (int i = 0; i < NC; i++) begin
         if (cl.req_out[i]) age[i]++;
         else age[i] = 0;
         if (lat[i] != 0 && age[i] == lat[i]) d[i] = 1'b1;
      end
      cl.done_in = d;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);
      cl.done_in = '0;
      setLat(0, 0, 0, 0);
      for (int i = 0; i < NC; i++) age[i] = 0;
      repeat (2) @(posedge pclk);
      #2;
      checkOutput("rst req",     32'(cl.req_out),       32'h0);
      checkOutput("rst busy",    32'(busy_out),         32'h0);
      checkOutput("rst fstart",  32'(frame_start_out),  32'h0);
      checkOutput("rst fcnt",    32'(frame_cnt_out),    32'h0);
      checkOutput("rst terr",    32'(timeout_err_out),  32'h0);
      checkOutput("rst overrun", 32'(overrun_out),      32'h0);
      rst_n = 1'b1;
      tick();
      tick();

      // Empty mask for three frames
      pulses   = 0;
      reqOr    = '0;
      busySeen = 1'b0;
      for (int f = 0; f < 3; f++) begin
         applyStimulus(1'b1, 4'b0000, 1'b0);
         expFrames++;
         for (int c = 0; c < 5; c++) begin
            if (c == 3) applyStimulus(1'b0, 4'b0000, 1'b0);
            tick();
            pulses   += int'(frame_start_out);
            reqOr    |= cl.req_out;
            busySeen |= busy_out;
         end
      end
      checkOutput("m0 pulses", 32'(pulses),        32'd3);
      checkOutput("m0 fcnt",   32'(frame_cnt_out), 32'd3);
      checkOutput("m0 req",    32'(reqOr),         32'h0);
      checkOutput("m0 busy",   32'(busySeen),      32'h0);

      // Mask 1011, every client answers after 3 cycles
      setLat(3, 3, 3, 3);
      applyStimulus(1'b1, 4'b1011, 1'b0);
      expFrames++;
      for (int k = 0; k < 13; k++) begin
         tick();
         checkOutput($sformatf("seq req c%0d", k + 1), 32'(cl.req_out), 32'(exp35[k]));
         checkOutput($sformatf("seq busy c%0d", k + 1), 32'(busy_out), (k < 12) ? 32'h1 : 32'h0);
         if (k == 0) begin
            checkOutput("seq fstart", 32'(frame_start_out), 32'h1);
            checkOutput("seq fcnt",   32'(frame_cnt_out),   32'(expFrames));
         end
      end
      applyStimulus(1'b0, 4'b1011, 1'b0);
      tick();
      tick();

      // Client 1 silent: timeout after 16 granted cycles, then client 3
      setLat(3, 0, 3, 3);
      applyStimulus(1'b1, 4'b1010, 1'b0);
      expFrames++;
      hold = 0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (cl.req_out == 4'b0010) hold++;
         if (k == 1)  checkOutput("to fcnt", 32'(frame_cnt_out), 32'(expFrames));
         if (k == 16) checkOutput("to terr early", 32'(timeout_err_out), 32'h0);
      end
      checkOutput("to hold", 32'(hold), 32'd16);
      tick();
      checkOutput("to req gap", 32'(cl.req_out),      32'h0);
      checkOutput("to terr",    32'(timeout_err_out), 32'h2);
      tick();
      checkOutput("to req c3",  32'(cl.req_out),      32'h8);
      repeat (4) tick();
      checkOutput("to busy end", 32'(busy_out),    32'h0);
      checkOutput("to overrun",  32'(overrun_out), 32'h0);
      applyStimulus(1'b0, 4'b1010, 1'b0);
      tick();
      tick();

      // Vblank ends while client 0 holds the grant
      setLat(0, 0, 0, 0);
      applyStimulus(1'b1, 4'b0001, 1'b0);
      expFrames++;
      tick();
      checkOutput("ov req", 32'(cl.req_out), 32'h1);
      tick();
      applyStimulus(1'b0, 4'b0001, 1'b0);
      tick();
      checkOutput("ov req drop", 32'(cl.req_out),  32'h0);
      checkOutput("ov flag",     32'(overrun_out), 32'h1);
      checkOutput("ov busy",     32'(busy_out),    32'h0);
      setLat(3, 3, 3, 3);
      applyStimulus(1'b1, 4'b1011, 1'b0);
      expFrames++;
      tick();
      checkOutput("ov restart req",  32'(cl.req_out),      32'h1);
      checkOutput("ov restart fst",  32'(frame_start_out), 32'h1);
      checkOutput("ov restart fcnt", 32'(frame_cnt_out),   32'(expFrames));
      repeat (12) tick();
      checkOutput("ov frame busy", 32'(busy_out), 32'h0);
      applyStimulus(1'b0, 4'b1011, 1'b0);
      tick();
      tick();
      checkOutput("ov sticky",   32'(overrun_out),     32'h1);
      checkOutput("terr sticky", 32'(timeout_err_out), 32'h2);
      applyStimulus(1'b0, 4'b0000, 1'b1);
      tick();
      applyStimulus(1'b0, 4'b0000, 1'b0);
      checkOutput("clr overrun", 32'(overrun_out),     32'h0);
      checkOutput("clr terr",    32'(timeout_err_out), 32'h0);

      // Done on the expiry cycle wins over the timeout
      setLat(16, 0, 0, 0);
      applyStimulus(1'b1, 4'b0001, 1'b0);
      expFrames++;
      for (int k = 1; k <= 16; k++) tick();
      checkOutput("tie req c16", 32'(cl.req_out), 32'h1);
      tick();
      checkOutput("tie req c17", 32'(cl.req_out),      32'h0);
      checkOutput("tie terr",    32'(timeout_err_out), 32'h0);
      tick();
      checkOutput("tie busy",    32'(busy_out),        32'h0);
      applyStimulus(1'b0, 4'b0001, 1'b0);
      tick();
      tick();

      // Clear and a new timeout in the same cycle: the set survives
      setLat(0, 0, 0, 0);
      applyStimulus(1'b1, 4'b0001, 1'b0);
      expFrames++;
      for (int k = 1; k <= 16; k++) tick();
      applyStimulus(1'b1, 4'b0001, 1'b1);
      tick();
      applyStimulus(1'b1, 4'b0001, 1'b0);
      checkOutput("clrset terr", 32'(timeout_err_out), 32'h1);
      checkOutput("clrset req",  32'(cl.req_out),      32'h0);
      tick();
      checkOutput("clrset hold", 32'(timeout_err_out), 32'h1);
      checkOutput("clrset busy", 32'(busy_out),        32'h0);
      applyStimulus(1'b0, 4'b0001, 1'b1);
      tick();
      applyStimulus(1'b0, 4'b0001, 1'b0);
      checkOutput("clr terr2", 32'(timeout_err_out), 32'h0);
      tick();

      // Asynchronous reset in the middle of a grant
      applyStimulus(1'b1, 4'b0001, 1'b0);
      expFrames++;
      tick();
      tick();
      checkOutput("ar req before", 32'(cl.req_out),    32'h1);
      checkOutput("ar fcnt before", 32'(frame_cnt_out), 32'(expFrames));
      #1 rst_n = 1'b0;
      #1;
      checkOutput("ar req",     32'(cl.req_out),      32'h0);
      checkOutput("ar busy",    32'(busy_out),        32'h0);
      checkOutput("ar fstart",  32'(frame_start_out), 32'h0);
      checkOutput("ar fcnt",    32'(frame_cnt_out),   32'h0);
      checkOutput("ar terr",    32'(timeout_err_out), 32'h0);
      checkOutput("ar overrun", 32'(overrun_out),     32'h0);
      @(posedge pclk);
      #2 rst_n = 1'b1;
      tick();
      checkOutput("ar rel fstart", 32'(frame_start_out), 32'h1);
      checkOutput("ar rel fcnt",   32'(frame_cnt_out),   32'h1);
      checkOutput("ar rel req",    32'(cl.req_out),      32'h1);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
